// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types and constants for the JTAG master.
//   op_e     - command op-codes (reserved code behaves as TAP reset)
//   state_e  - master FSM states
//   TMS_*    - TMS patterns; bit i is the TMS value driven for TCK i
//   hdr_tms / hdr_len - header pattern and header length for an op
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_DR  = 2'd0,
    OP_IR  = 2'd1,
    OP_RST = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_HDR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TRL   = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Five TMS=1 clocks reach Test-Logic-Reset from any state, the sixth
  // (TMS=0) parks the TAP in Run-Test/Idle.
  localparam logic [5:0] TMS_HDR_RST = 6'b011111;
  // Idle -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [5:0] TMS_HDR_DR  = 6'b000001;
  // Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [5:0] TMS_HDR_IR  = 6'b000011;
  // Exit1 -> Update -> Idle
  localparam logic [1:0] TMS_TRL     = 2'b01;

  function automatic logic [5:0] hdr_tms(input op_e op);
    case (op)
      OP_DR:   return TMS_HDR_DR;
      OP_IR:   return TMS_HDR_IR;
      default: return TMS_HDR_RST;
    endcase
  endfunction

  function automatic logic [2:0] hdr_len(input op_e op);
    case (op)
      OP_DR:   return 3'd3;
      OP_IR:   return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider.
//   clk, rst_n - system clock, async active-low reset
//   en         - run TCK; while low TCK is held low and the divider cleared
//   tck        - test clock, low for CLK_DIV cycles then high for CLK_DIV
//   tck_rise   - high in the clk cycle whose closing edge raises tck
//   tck_fall   - high in the clk cycle whose closing edge lowers tck
// Enabling always starts with a full low phase.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
  assign tck_rise = wrap && !tck;
  assign tck_fall = wrap && tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: command-driven JTAG shift engine.
//   ACLK, ARESETN         - clock, async active-low reset
//   cmd_valid/cmd_ready   - command handshake; cmd_op, cmd_len, cmd_data
//   rsp_valid/rsp_ready   - response handshake; rsp_data = captured TDO
//   TCK, TMS, TDI, TDO    - JTAG pins
//   dbg_state             - current FSM state
// Handshakes: a transfer happens on the rising ACLK edge where valid and
// ready are both high; valid, once raised by the producer, is held with
// stable payload until that edge. cmd_ready is high only in IDLE and
// rsp_valid only in RESP, so at most one operation is ever in flight.
// Every operation (boot included) is a TMS bit sequence: a header loaded
// into tms_sh, optionally cmd_len shift bits, optionally a 2-bit trailer.
// TMS/TDI advance on tck_fall so they change only as a low phase starts.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output state_e            dbg_state
);

  // Counter wide enough for both the shift length and the 6-bit headers.
  localparam int BC_W = (LEN_W > 3) ? LEN_W : 3;

  state_e            state;
  op_e               seq;      // sequence kind; OP_RST never enters SHIFT
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   len_q;
  logic [5:0]        tms_sh;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_next;
  logic [DATA_W-1:0] mask_q;   // one-hot: rsp_data bit for the current TCK
  logic              tck_run;
  logic              tck_rise;
  logic              tck_fall;

  logic [BC_W-1:0]   len_in;
  logic [BC_W-1:0]   len_eff;
  op_e               op_in;
  logic [5:0]        hdr_pat;
  logic [BC_W-1:0]   hdr_last;

  assign dbg_state = state;
  assign sh_next   = sh_q >> 1;
  assign tck_run   = (state == ST_BOOT) || (state == ST_HDR) ||
                     (state == ST_SHIFT) || (state == ST_TRL);

  assign len_in  = BC_W'(cmd_len);
  assign len_eff = (len_in > BC_W'(DATA_W)) ? BC_W'(DATA_W) : len_in;

  // Zero-length shifts and the reserved code degrade to a TAP reset.
  always_comb begin
    op_in = OP_RST;
    if ((cmd_op == OP_DR) && (cmd_len != '0)) op_in = OP_DR;
    else if ((cmd_op == OP_IR) && (cmd_len != '0)) op_in = OP_IR;
  end

  assign hdr_pat  = hdr_tms(op_in);
  assign hdr_last = BC_W'(hdr_len(seq)) - BC_W'(1);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .en       (tck_run),
    .tck      (TCK),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_BOOT;
      seq       <= OP_RST;
      bit_cnt   <= '0;
      len_q     <= '0;
      tms_sh    <= TMS_HDR_RST;
      sh_q      <= '0;
      mask_q    <= '0;
      rsp_data  <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT, ST_HDR: begin
          if (tck_fall) begin
            if (bit_cnt == hdr_last) begin
              bit_cnt <= '0;
              if (state == ST_BOOT) begin
                state     <= ST_IDLE;
                cmd_ready <= 1'b1;
              end else if (seq == OP_RST) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
              end else begin
                state <= ST_SHIFT;
                TMS   <= (len_q == BC_W'(1));
                TDI   <= sh_q[0];
              end
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
              tms_sh  <= tms_sh >> 1;
              TMS     <= tms_sh[1];
            end
          end
        end

        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_HDR;
            cmd_ready <= 1'b0;
            seq       <= op_in;
            len_q     <= len_eff;
            sh_q      <= cmd_data;
            mask_q    <= DATA_W'(1);
            rsp_data  <= '0;
            bit_cnt   <= '0;
            tms_sh    <= hdr_pat;
            TMS       <= hdr_pat[0];
          end
        end

        ST_SHIFT: begin
          if (tck_rise) begin
            if (TDO) rsp_data <= rsp_data | mask_q;
          end else if (tck_fall) begin
            if (bit_cnt == len_q - BC_W'(1)) begin
              state   <= ST_TRL;
              bit_cnt <= '0;
              tms_sh  <= {4'b0000, TMS_TRL};
              TMS     <= TMS_TRL[0];
              TDI     <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
              sh_q    <= sh_next;
              mask_q  <= mask_q << 1;
              TDI     <= sh_next[0];
              // TMS=1 only on the final shift bit (moves to Exit1).
              TMS     <= ((bit_cnt + BC_W'(1)) == (len_q - BC_W'(1)));
            end
          end
        end

        ST_TRL: begin
          if (tck_fall) begin
            if (bit_cnt == BC_W'(1)) begin
              state     <= ST_RESP;
              bit_cnt   <= '0;
              rsp_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
              tms_sh  <= tms_sh >> 1;
              TMS     <= tms_sh[1];
            end
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= ST_BOOT;
          seq       <= OP_RST;
          bit_cnt   <= '0;
          tms_sh    <= TMS_HDR_RST;
          TMS       <= 1'b1;
          TDI       <= 1'b0;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed bench for jtag_master (DATA_W=32, CLK_DIV=2).
// TMS/TDI are logged at every TCK rising edge; TDO is either looped back
// from TDI or held high.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;
  localparam int CLK_DIV = 2;

  // ---------------- clock / reset ----------------
  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op    = '0;
  logic [LEN_W-1:0]  cmd_len   = '0;
  logic [DATA_W-1:0] cmd_data  = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              TCK, TMS, TDI, TDO;
  state_e            dbg_state;
  logic              tdo_hold = 1'b0;

  assign TDO = tdo_hold ? 1'b1 : TDI;

  jtag_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- pin monitors ----------------
  logic tms_q[$];
  logic tdi_q[$];
  int   base = 0;
  int   viol = 0;
  logic prev_tms = 1'b1;
  logic prev_tdi = 1'b0;

  always @(posedge TCK) begin
    tms_q.push_back(TMS);
    tdi_q.push_back(TDI);
  end

  // TMS/TDI must never move while TCK is high.
  always @(negedge ACLK) begin
    if (TCK && ((TMS !== prev_tms) || (TDI !== prev_tdi))) viol++;
    prev_tms = TMS;
    prev_tdi = TDI;
  end

  function automatic int tck_seen();
    return tms_q.size() - base;
  endfunction

  function automatic logic [63:0] log_bits(input bit use_tdi);
    logic [63:0] v = '0;
    for (int i = base; i < tms_q.size(); i++)
      if (i - base < 64) v[i - base] = use_tdi ? tdi_q[i] : tms_q[i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_boot(output int cyc, output logic saw_rsp);
    cyc = 0;
    saw_rsp = 1'b0;
    @(negedge ACLK);
    base = tms_q.size();
    ARESETN = 1'b1;
    while (cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      if (rsp_valid) saw_rsp = 1'b1;
      if (cmd_ready) break;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] data, input logic keep_valid);
    int n = 0;
    @(negedge ACLK);
    while (!cmd_ready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    base = tms_q.size();
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    @(posedge ACLK);
    #1;
    // Junk after acceptance must have no effect.
    cmd_valid = keep_valid;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_len = LEN_W'($urandom_range(1, 63));
    cmd_data = $urandom();
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%b required 1", name, rsp_valid);
    end
  endtask

  task automatic finish_rsp(input string name);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_in_resp: cmd_ready=%b required 0", name, cmd_ready);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(posedge ACLK);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_hs: cmd_ready=%b rsp_valid=%b required 1 0",
               name, cmd_ready, rsp_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    logic saw;
    logic [63:0] t;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if (TCK !== 1'b0 || TMS !== 1'b1 || TDI !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: TCK=%b TMS=%b TDI=%b required 0 1 0", TCK, TMS, TDI);
    end
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_handshake: cmd_ready=%b rsp_valid=%b rsp_data=%h required 0 0 0",
               cmd_ready, rsp_valid, rsp_data);
    end
    checks++;
    if (dbg_state !== ST_BOOT) begin
      errors++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_BOOT);
    end
    do_boot(cyc, saw);
    checks++;
    if (cyc < 24 || cyc > 26) begin
      errors++;
      $display("FAIL boot_latency: cycles=%0d required 24..26", cyc);
    end
    checks++;
    if (tck_seen() !== 6) begin
      errors++;
      $display("FAIL boot_tck_count: got %0d required 6", tck_seen());
    end
    t = log_bits(1'b0);
    checks++;
    if (t !== 64'h1F) begin
      errors++;
      $display("FAIL boot_tms: got %h required %h", t, 64'h1F);
    end
  endtask

  task automatic test_dr8();
    logic [63:0] t, d;
    tdo_hold = 1'b0;
    send_cmd(2'd0, 6'd8, 32'h0000_00A5, 1'b0);
    wait_rsp("dr8");
    t = log_bits(1'b0);
    d = log_bits(1'b1) >> 3;
    checks++;
    if (tck_seen() !== 13) begin
      errors++;
      $display("FAIL dr8_tck_count: got %0d required 13", tck_seen());
    end
    checks++;
    if (t !== 64'h0C01) begin
      errors++;
      $display("FAIL dr8_tms: got %h required %h", t, 64'h0C01);
    end
    checks++;
    if (d[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL dr8_tdi: got %h required a5", d[7:0]);
    end
    checks++;
    if (rsp_data !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL dr8_rsp: got %h required 000000a5", rsp_data);
    end
    finish_rsp("dr8");
  endtask

  task automatic test_ir5();
    logic [63:0] t, d;
    tdo_hold = 1'b1;
    send_cmd(2'd1, 6'd5, 32'h0000_0009, 1'b0);
    wait_rsp("ir5");
    t = log_bits(1'b0);
    d = log_bits(1'b1) >> 4;
    checks++;
    if (tck_seen() !== 11) begin
      errors++;
      $display("FAIL ir5_tck_count: got %0d required 11", tck_seen());
    end
    checks++;
    if (t !== 64'h0303) begin
      errors++;
      $display("FAIL ir5_tms: got %h required %h", t, 64'h0303);
    end
    checks++;
    if (d[4:0] !== 5'h09) begin
      errors++;
      $display("FAIL ir5_tdi: got %h required 09", d[4:0]);
    end
    checks++;
    if (rsp_data !== 32'h0000_001F) begin
      errors++;
      $display("FAIL ir5_rsp: got %h required 0000001f", rsp_data);
    end
    finish_rsp("ir5");
    tdo_hold = 1'b0;
  endtask

  task automatic test_clamp();
    logic [63:0] t;
    tdo_hold = 1'b0;
    send_cmd(2'd0, 6'd40, 32'hDEAD_BEEF, 1'b0);
    wait_rsp("clamp");
    t = log_bits(1'b0);
    checks++;
    if (tck_seen() !== 37) begin
      errors++;
      $display("FAIL clamp_tck_count: got %0d required 37", tck_seen());
    end
    checks++;
    if (t !== 64'h0000_000C_0000_0001) begin
      errors++;
      $display("FAIL clamp_tms: got %h required 0000000c00000001", t);
    end
    checks++;
    if (rsp_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL clamp_rsp: got %h required deadbeef", rsp_data);
    end
    finish_rsp("clamp");
  endtask

  task automatic test_tap_reset();
    logic [1:0]       ops [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [LEN_W-1:0] lens[4] = '{6'd8, 6'd8, 6'd0, 6'd0};
    logic [63:0] t;
    tdo_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_cmd(ops[k], lens[k], 32'hFFFF_FFFF, 1'b0);
      wait_rsp("tapreset");
      t = log_bits(1'b0);
      checks++;
      if (tck_seen() !== 6 || t !== 64'h1F) begin
        errors++;
        $display("FAIL tapreset_seq[%0d]: tcks=%0d tms=%h required 6 1f", k, tck_seen(), t);
      end
      checks++;
      if (rsp_data !== '0) begin
        errors++;
        $display("FAIL tapreset_rsp[%0d]: got %h required 0", k, rsp_data);
      end
      finish_rsp("tapreset");
    end
    tdo_hold = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] t;
    int bad = 0;
    tdo_hold = 1'b0;
    // cmd_valid stays high with junk for the whole operation and stall.
    send_cmd(2'd0, 6'd16, 32'h1234_5678, 1'b1);
    wait_rsp("bp");
    t = log_bits(1'b0);
    checks++;
    if (tck_seen() !== 21 || t !== 64'h000C_0001) begin
      errors++;
      $display("FAIL bp_seq: tcks=%0d tms=%h required 21 c0001", tck_seen(), t);
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_5678 || cmd_ready !== 1'b0) bad++;
      @(negedge ACLK);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_stall: unstable cycles=%0d required 0", bad);
    end
    checks++;
    if (rsp_data !== 32'h0000_5678) begin
      errors++;
      $display("FAIL bp_rsp: got %h required 00005678", rsp_data);
    end
    finish_rsp("bp");
  endtask

  task automatic test_back_to_back();
    tdo_hold = 1'b0;
    send_cmd(2'd0, 6'd4, 32'hFFFF_FFF6, 1'b0);
    wait_rsp("b2b0");
    checks++;
    if (tck_seen() !== 9 || rsp_data !== 32'h0000_0006) begin
      errors++;
      $display("FAIL b2b0: tcks=%0d rsp=%h required 9 00000006", tck_seen(), rsp_data);
    end
    finish_rsp("b2b0");
    send_cmd(2'd0, 6'd12, 32'hFFFF_F5A3, 1'b0);
    wait_rsp("b2b1");
    checks++;
    if (tck_seen() !== 17 || rsp_data !== 32'h0000_05A3) begin
      errors++;
      $display("FAIL b2b1: tcks=%0d rsp=%h required 17 000005a3", tck_seen(), rsp_data);
    end
    finish_rsp("b2b1");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc;
    logic saw;
    logic [63:0] t;
    tdo_hold = 1'b0;
    send_cmd(2'd0, 6'd8, 32'h0000_00A5, 1'b0);
    // 3 header TCKs + shift bits 0..3 = 7 rising edges.
    while (tck_seen() < 7 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (tck_seen() !== 7) begin
      errors++;
      $display("FAIL mid_reach: tcks=%0d required 7", tck_seen());
    end
    ARESETN = 1'b0;
    #1;
    checks++;
    if (TCK !== 1'b0 || TMS !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== ST_BOOT) begin
      errors++;
      $display("FAIL mid_abort: TCK=%b TMS=%b rsp_valid=%b state=%0d required 0 1 0 0",
               TCK, TMS, rsp_valid, dbg_state);
    end
    repeat (3) @(negedge ACLK);
    do_boot(cyc, saw);
    t = log_bits(1'b0);
    checks++;
    if (tck_seen() !== 6 || t !== 64'h1F || cyc < 24 || cyc > 26) begin
      errors++;
      $display("FAIL mid_reboot: tcks=%0d tms=%h cycles=%0d required 6 1f 24..26",
               tck_seen(), t, cyc);
    end
    checks++;
    if (saw !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_stale_rsp: seen=%b rsp_valid=%b required 0 0", saw, rsp_valid);
    end
    send_cmd(2'd0, 6'd8, 32'h0000_003C, 1'b0);
    wait_rsp("mid_after");
    checks++;
    if (rsp_data !== 32'h0000_003C) begin
      errors++;
      $display("FAIL mid_after_rsp: got %h required 0000003c", rsp_data);
    end
    finish_rsp("mid_after");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_dr8();
    test_ir5();
    test_clamp();
    test_tap_reset();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL pin_phase: changes while TCK high=%0d required 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
